// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access engine. Latches one access on
// start, either faults immediately (misaligned / illegal funct3) or performs a
// single word-aligned req/ready transaction, and returns extended load data.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  isStore,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           storeData,
  output logic [31:0]           loadData,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [3:0]            memByteEn,
  output logic [31:0]           memWData,
  input  logic                  memReady,
  input  logic [31:0]           memRData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t     state;
  logic       st_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  // Unsupported funct3 for the direction, or a halfword/word that straddles its natural alignment.
  function automatic logic is_illegal(input logic st, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    if (st) bad = (f3 > 3'b010);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((f3[1:0] == 2'b01) && off[0])         bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (off != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

  // Lane enables: size mask shifted to the byte offset within the word.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] replicate_store(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/halfword from the read word and extend it per funct3[2].
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = $signed(rdata[{off, 3'b000} +: 8]);
    h = $signed(rdata[{off[1], 4'b0000} +: 16]);
    case (f3[1:0])
      2'b00: begin
        if (f3[2]) r = {24'd0, b};
        else       r = {{24{b[7]}}, b};
      end
      2'b01: begin
        if (f3[2]) r = {16'd0, h};
        else       r = {{16{h[15]}}, h};
      end
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Access FSM with registered handshake, status and memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      st_q      <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memByteEn <= 4'd0;
      memWData  <= 32'd0;
      loadData  <= 32'd0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            st_q  <= isStore;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            busy  <= 1'b1;
            if (is_illegal(isStore, funct3, addr[1:0])) begin
              state <= S_FAULT;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= S_ACCESS;
              memReq    <= 1'b1;
              memWe     <= isStore;
              memAddr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
              memByteEn <= byte_enables(funct3, addr[1:0]);
              memWData  <= replicate_store(funct3, storeData);
            end
          end
        end
        S_ACCESS: begin
          if (memReady) begin
            state  <= S_DONE;
            memReq <= 1'b0;
            memWe  <= 1'b0;
            done   <= 1'b1;
            if (!st_q) loadData <= extract_load(f3_q, off_q, memRData);
          end
        end
        S_DONE, S_FAULT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          memReq <= 1'b0;
          memWe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table, hand-built corner sequences and
// random transactions checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic        busy;
  logic        done;
  logic        fault;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteEn;
  logic [31:0] memWData;
  logic        memReady;
  logic [31:0] memRData;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ld_model = 32'd0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .isStore(isStore), .funct3(funct3),
    .addr(addr), .storeData(storeData), .loadData(loadData), .busy(busy),
    .done(done), .fault(fault), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memByteEn(memByteEn), .memWData(memWData), .memReady(memReady), .memRData(memRData)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    logic        ef;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model computed with plain arithmetic from the access rules.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       output logic ef, output logic [3:0] be,
                       output logic [31:0] wd, output logic [31:0] ld);
    int   size, off;
    longint v;
    size = int'(f3) % 4;
    off  = int'(a % 4);
    if (st) ef = (f3 > 2);
    else    ef = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (size == 1 && (off % 2) != 0) ef = 1'b1;
    if (size == 2 && off != 0)       ef = 1'b1;
    if (size == 0)      be = 4'(1 << off);
    else if (size == 1) be = 4'(3 << off);
    else                be = 4'd15;
    if (size == 0)      wd = (sd % 256) * 32'h0101_0101;
    else if (size == 1) wd = (sd % 65536) * 32'h0001_0001;
    else                wd = sd;
    if (size == 0) begin
      v = (longint'(rd) >> (8 * off)) % 256;
      if (f3 < 4 && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = (longint'(rd) >> (16 * (off / 2))) % 65536;
      if (f3 < 4 && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    ld = 32'(v);
  endtask

  // One complete access starting from IDLE; ends in the cycle after done (IDLE).
  task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         input int dly, input logic ef, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] eld);
    logic [31:0] exp_ld;
    exp_ld = (ef || st) ? ld_model : eld;
    start = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = sd; memReady = 1'b0;
    step();
    start = 1'b0; isStore = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; storeData = $urandom;
    if (ef) begin
      chk({tag, " fault.done"}, 32'(done), 32'd1);
      chk({tag, " fault.fault"}, 32'(fault), 32'd1);
      chk({tag, " fault.memReq"}, 32'(memReq), 32'd0);
      chk({tag, " fault.loadData"}, loadData, exp_ld);
      memReady = 1'($urandom);
      step();
      chk({tag, " fault.after"}, {29'd0, done, fault, memReq}, 32'd0);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        chk({tag, " acc.memReq"}, 32'(memReq), 32'd1);
        chk({tag, " acc.memWe"}, 32'(memWe), 32'(st));
        chk({tag, " acc.memAddr"}, memAddr, a & 32'hFFFF_FFFC);
        chk({tag, " acc.memByteEn"}, 32'(memByteEn), 32'(be));
        if (st) chk({tag, " acc.memWData"}, memWData, wd);
        chk({tag, " acc.done"}, 32'(done), 32'd0);
        memReady = (i == dly);
        memRData = (i == dly) ? rd : $urandom;
        step();
      end
      memReady = 1'($urandom); memRData = $urandom;
      chk({tag, " end.done"}, 32'(done), 32'd1);
      chk({tag, " end.fault"}, 32'(fault), 32'd0);
      chk({tag, " end.memReq"}, 32'(memReq), 32'd0);
      chk({tag, " end.loadData"}, loadData, exp_ld);
      step();
    end
    chk({tag, " idle.busy_done"}, {30'd0, busy, done}, 32'd0);
    chk({tag, " idle.loadData"}, loadData, exp_ld);
    memReady = 1'b0;
    ld_model = exp_ld;
  endtask

  initial begin
    int ndone, nbad;
    logic        r_st, r_ef;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_sd, r_rd, r_wd, r_ld;
    logic [3:0]  r_be;

    tbl[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    tbl[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'h9ABC_0000, 3, 1'b0, 4'b1100, 32'h0,         32'h0000_9ABC};
    tbl[2]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 32'h0,         0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    tbl[3]  = '{1'b1, 3'b010, 32'h0000_0006, 32'h5555_5555, 32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, 3'b001, 32'h0000_0003, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[5]  = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 3'b010, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    tbl[7]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,         32'h8001_0000, 0, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
    tbl[8]  = '{1'b0, 3'b100, 32'h0000_0002, 32'h0,         32'h00AB_0000, 0, 1'b0, 4'b0100, 32'h0,         32'h0000_00AB};
    tbl[9]  = '{1'b1, 3'b001, 32'h0000_0002, 32'hFFFF_BEEF, 32'h0,         0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    tbl[10] = '{1'b1, 3'b010, 32'h0000_0004, 32'h0123_4567, 32'h0,         2, 1'b0, 4'b1111, 32'h0123_4567, 32'h0};
    tbl[11] = '{1'b1, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[12] = '{1'b0, 3'b110, 32'h0000_0000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[13] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0,         32'h0000_007F, 0, 1'b0, 4'b0001, 32'h0,         32'h0000_007F};

    rst_n = 1'b0; start = 1'b0; isStore = 1'b0; funct3 = 3'd0; addr = 32'd0;
    storeData = 32'd0; memReady = 1'b0; memRData = 32'd0;
    step(); step();
    chk("reset.ctrl", {27'd0, busy, done, fault, memReq, memWe}, 32'd0);
    chk("reset.loadData", loadData, 32'd0);
    chk("reset.memAddr", memAddr, 32'd0);
    chk("reset.memByteEn", 32'(memByteEn), 32'd0);
    chk("reset.memWData", memWData, 32'd0);
    rst_n = 1'b1;
    step();

    // Directed vector table.
    foreach (tbl[i])
      run_txn($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].sd, tbl[i].rd,
              tbl[i].dly, tbl[i].ef, tbl[i].be, tbl[i].wd, tbl[i].ld);

    // start held high while busy (carrying a store) must be ignored.
    start = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h40; memReady = 1'b0;
    step();
    isStore = 1'b1; funct3 = 3'b000; addr = 32'h0; storeData = 32'hFFFF_FFFF;
    ndone = 0; nbad = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) start = 1'b0;
      if (done) ndone++;
      if (memReq && memWe) nbad++;
      if (c >= 5 && memReq) nbad++;
      memReady = (c == 3);
      memRData = (c == 3) ? 32'h1122_3344 : $urandom;
      step();
    end
    memReady = 1'b0;
    chk("busy_start.ndone", 32'(ndone), 32'd1);
    chk("busy_start.extra_req", 32'(nbad), 32'd0);
    chk("busy_start.loadData", loadData, 32'h1122_3344);
    ld_model = 32'h1122_3344;

    // Reset asserted in the middle of a stalled load.
    start = 1'b1; isStore = 1'b0; funct3 = 3'b000; addr = 32'h8;
    step();
    start = 1'b0;
    step();
    chk("rst_mid.memReq_before", 32'(memReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.memReq", 32'(memReq), 32'd0);
    chk("rst_mid.busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_mid.loadData", loadData, 32'd0);
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      memReady = 1'b1;
      if (done || memReq) ndone++;
      step();
    end
    memReady = 1'b0;
    chk("rst_mid.no_done", 32'(ndone), 32'd0);
    ld_model = 32'd0;

    // Random back-to-back transactions against the reference model.
    for (int n = 0; n < 300; n++) begin
      r_st = 1'($urandom);
      r_f3 = 3'($urandom);
      r_a  = $urandom;
      r_sd = $urandom;
      r_rd = $urandom;
      model(r_st, r_f3, r_a, r_sd, r_rd, r_ef, r_be, r_wd, r_ld);
      run_txn($sformatf("rnd%0d", n), r_st, r_f3, r_a, r_sd, r_rd,
              int'($urandom_range(0, 3)), r_ef, r_be, r_wd, r_ld);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
